// File: rtl/mem_responder.sv
// Zero-wait-state memory responder: byte-enabled writes, pipelined reads with fixed latency.
// Optional IRQ register and cycle counter are enabled by defining MEM_RESPONDER_IRQ_EN.
module mem_responder #(
  parameter int unsigned ADDR_BITS    = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] IRQ_ADDR     = 32'hAFFF_FFF4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        irq
);

  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam logic [31:0] CNT_ADDR = IRQ_ADDR + 32'd4;

  logic [ADDR_BITS-1:0] word_idx;
  logic                 in_ram_window;
  logic                 sel_irq;
  logic                 sel_cnt;
  logic                 sel_ram;
  logic                 rd_issue;
  logic                 ram_we;
  logic                 unused_addr_bits;

  assign word_idx         = address[ADDR_BITS+1:2];
  assign in_ram_window    = (address[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign sel_ram          = in_ram_window && !sel_irq && !sel_cnt;
  assign rd_issue         = read && !reset;
  assign ram_we           = write && !reset && sel_ram;
  assign unused_addr_bits = ^address[1:0];

  // Non-RAM read source, resolved at the issue edge.
  logic [31:0] alt_d;

`ifdef MEM_RESPONDER_IRQ_EN
  logic        irq_q, irq_d;
  logic [31:0] cnt_q, cnt_d;

  assign sel_irq = (address[31:2] == IRQ_ADDR[31:2]);
  assign sel_cnt = (address[31:2] == CNT_ADDR[31:2]);

  always_comb begin
    irq_d = irq_q;
    cnt_d = cnt_q + 32'd1;
    if (write && sel_irq && byteenable[0]) begin
      irq_d = writedata[0];
    end
  end

  always_comb begin
    alt_d = 32'hDEAD_BEEF;
    if (sel_irq) begin
      alt_d = {31'b0, irq_q};
    end else if (sel_cnt) begin
      alt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      irq_q <= irq_d;
      cnt_q <= cnt_d;
    end
  end

  assign irq = irq_q;
`else
  assign sel_irq = 1'b0;
  assign sel_cnt = 1'b0;
  assign irq     = 1'b0;

  always_comb begin
    alt_d = 32'hDEAD_BEEF;
  end
`endif

  // RAM storage: uninitialised, untouched by reset, registered read port.
  logic [31:0] mem_q [DEPTH];
  logic [31:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          mem_q[word_idx][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
    if (rd_issue) begin
      ram_rd_q <= mem_q[word_idx];
    end
  end

  // Stage 0 of the return pipeline: source select plus the RAM/alt registers.
  logic [31:0] alt_q;
  logic        use_ram_q;
  logic [READ_LATENCY-1:0] vld_q, vld_d;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = rd_issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alt_q     <= '0;
      use_ram_q <= 1'b0;
      vld_q     <= '0;
    end else begin
      vld_q <= vld_d;
      if (rd_issue) begin
        alt_q     <= alt_d;
        use_ram_q <= sel_ram;
      end
    end
  end

  logic [31:0] stg_data [READ_LATENCY];
  assign stg_data[0] = use_ram_q ? ram_rd_q : alt_q;

  // The final stage only loads on a valid beat so readdata holds between pulses.
  for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
    logic [31:0] data_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= '0;
      end else if ((gi < READ_LATENCY - 1) || vld_q[gi-1]) begin
        data_q <= stg_data[gi-1];
      end
    end
    assign stg_data[gi] = data_q;
  end

  assign readdata      = stg_data[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (latency 1, 2, 8) share one stimulus
// stream and are compared every cycle against a transaction-level reference model.
module tb_mem_responder;

  localparam int          AB    = 6;
  localparam int          DEPTH = 1 << AB;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] IRQA  = 32'hAFFF_FFF4;
  localparam int          NK    = 3;
  localparam int          MAXC  = 8192;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 8);
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        read = 1'b0;
  logic [31:0] rd [NK];
  logic        rdv [NK];
  logic        irq_w [NK];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NK; gi++) begin : g_dut
    localparam int unsigned LK = (gi == 0) ? 1 : ((gi == 1) ? 2 : 8);
    mem_responder #(
      .ADDR_BITS(AB), .BASE_ADDR(BASE), .READ_LATENCY(LK), .IRQ_ADDR(IRQA)
    ) u_dut (
      .clk(clk), .reset(reset), .address(address), .write(write),
      .writedata(writedata), .byteenable(byteenable), .read(read),
      .readdata(rd[gi]), .readdatavalid(rdv[gi]), .irq(irq_w[gi])
    );
  end

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  logic        irq_m = 1'b0;
  logic [31:0] cnt_m = '0;
  bit          hv [MAXC];
  logic [31:0] hd [MAXC];
  logic [31:0] held [NK];
  int          p = -1;
  logic [31:0] rq [NK][$];
  int          rs [NK][$];
  int          checks = 0;
  int          errors = 0;

  function automatic bit is_irq(input logic [31:0] a);
`ifdef MEM_RESPONDER_IRQ_EN
    return (a >> 2) == (IRQA >> 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_cnt(input logic [31:0] a);
`ifdef MEM_RESPONDER_IRQ_EN
    return (a >> 2) == ((IRQA + 32'd4) >> 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit in_ram(input logic [31:0] a);
    longint unsigned la = longint'(a);
    longint unsigned lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4 * DEPTH) && !is_irq(a) && !is_cnt(a);
  endfunction

  function automatic int ram_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (is_irq(a)) return {31'b0, irq_m};
    if (is_cnt(a)) return cnt_m;
    if (in_ram(a)) return mem_m[ram_idx(a)];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (is_irq(a)) begin
      if (be[0]) irq_m = wd[0];
    end else if (in_ram(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[ram_idx(a)][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat=%0d cycle=%0d got=%h expected=%h", nm, lat_of(k), p, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare every instance.
  task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input bit rst);
    read = r; write = w; address = a; writedata = wd; byteenable = be; reset = rst;
    @(posedge clk);
    #1;
    p++;
    if (p >= MAXC) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", p, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst) begin
      for (int q = (p > 8 ? p - 8 : 0); q <= p; q++) hv[q] = 1'b0;
      irq_m = 1'b0;
      cnt_m = '0;
      for (int k = 0; k < NK; k++) held[k] = '0;
    end else begin
      hv[p] = r;
      hd[p] = model_read(a);
      if (w) model_write(a, wd, be);
      cnt_m = cnt_m + 32'd1;
    end
    for (int k = 0; k < NK; k++) begin
      int idx = p - lat_of(k) + 1;
      bit ev  = (idx >= 0) && hv[idx];
      if (ev) held[k] = hd[idx];
      chk("valid", k, {31'b0, rdv[k]}, {31'b0, ev});
      chk("data", k, rd[k], held[k]);
      chk("irq", k, {31'b0, irq_w[k]}, {31'b0, irq_m});
      if (rdv[k]) begin
        rq[k].push_back(rd[k]);
        rs[k].push_back(p);
      end
    end
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic clear_q();
    for (int k = 0; k < NK; k++) begin
      rq[k].delete();
      rs[k].delete();
    end
  endtask

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p_issue, p_r, late;
    for (int k = 0; k < NK; k++) held[k] = '0;

    tbl[0]  = '{1'b1, 1'b0, BASE + 32'h10,  32'h1234_5678, 4'hF, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, BASE + 32'h10,  32'hAABB_CCDD, 4'h5, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, BASE + 32'h10,  32'h0,         4'h0, 32'h12BB_56DD};
    tbl[3]  = '{1'b1, 1'b0, BASE + 32'h14,  32'h1122_3344, 4'h0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, BASE + 32'h14,  32'h0,         4'h0, 32'h0000_0005};
    tbl[5]  = '{1'b0, 1'b1, BASE + 32'h100, 32'h0,         4'h0, 32'hDEAD_BEEF};
    tbl[6]  = '{1'b1, 1'b0, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, BASE + 32'h0,   32'h0,         4'h0, 32'h0000_0000};
    tbl[8]  = '{1'b1, 1'b0, BASE + 32'h18,  32'hA5A5_A5A5, 4'h8, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, BASE + 32'h1B,  32'h0,         4'h0, 32'hA500_0006};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_0000,  32'h0,         4'h0, 32'hDEAD_BEEF};
    tbl[11] = '{1'b0, 1'b1, BASE + 32'hFC,  32'h0,         4'h0, 32'h0000_003F};

    // Reset, then idle: outputs must stay at their reset values.
    repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    idle(5);

    // Preload word i = i.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, BASE + 32'(4 * i), 32'(i), 4'hF, 1'b0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be, 1'b0);
      if (tbl[i].r) begin
        idle(9);
        for (int k = 0; k < NK; k++) chk($sformatf("vec%0d", i), k, rd[k], tbl[i].exp);
      end
      $display("txn %0d w=%0d r=%0d addr=%h wdata=%h be=%h", i, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].wd, tbl[i].be);
    end

    // Eight back-to-back reads: contiguous pulses, in order, at exact latency.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, BASE + 32'(4 * i), 32'(i), 4'hF, 1'b0);
    clear_q();
    p_issue = p + 1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, 1'b0);
    idle(10);
    for (int k = 0; k < NK; k++) begin
      chk("b2b_count", k, 32'(rq[k].size()), 32'd8);
      for (int i = 0; i < rq[k].size() && i < 8; i++) begin
        chk("b2b_data", k, rq[k][i], 32'(i));
        chk("b2b_cycle", k, 32'(rs[k][i]), 32'(p_issue + i + lat_of(k) - 1));
      end
    end
    $display("txn b2b reads issued at cycle %0d", p_issue);

    // Read and write to the same word in one cycle, then read again next cycle.
    clear_q();
    step(1'b1, 1'b1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 1'b0);
    idle(10);
    for (int k = 0; k < NK; k++) begin
      chk("rw_count", k, 32'(rq[k].size()), 32'd2);
      if (rq[k].size() == 2) begin
        chk("rw_old", k, rq[k][0], 32'h0000_0008);
        chk("rw_new", k, rq[k][1], 32'hCAFE_F00D);
      end
    end
    $display("txn read/write collision at %h", BASE + 32'h20);

`ifdef MEM_RESPONDER_IRQ_EN
    step(1'b0, 1'b1, IRQA, 32'h1, 4'h1, 1'b0);
    for (int k = 0; k < NK; k++) chk("irq_set", k, {31'b0, irq_w[k]}, 32'h1);
    step(1'b1, 1'b0, IRQA, 32'h0, 4'h0, 1'b0);
    idle(9);
    for (int k = 0; k < NK; k++) chk("irq_read", k, rd[k], 32'h1);
    step(1'b0, 1'b1, IRQA, 32'h0, 4'hE, 1'b0);
    for (int k = 0; k < NK; k++) chk("irq_be0", k, {31'b0, irq_w[k]}, 32'h1);
    step(1'b0, 1'b1, IRQA, 32'h0, 4'h1, 1'b0);
    for (int k = 0; k < NK; k++) chk("irq_clr", k, {31'b0, irq_w[k]}, 32'h0);
    clear_q();
    step(1'b1, 1'b0, IRQA + 32'd4, 32'h0, 4'h0, 1'b0);
    idle(9);
    step(1'b1, 1'b0, IRQA + 32'd4, 32'h0, 4'h0, 1'b0);
    idle(10);
    for (int k = 0; k < NK; k++) begin
      chk("cnt_count", k, 32'(rq[k].size()), 32'd2);
      if (rq[k].size() == 2) chk("cnt_delta", k, rq[k][1] - rq[k][0], 32'd10);
    end
    $display("txn irq register and counter sequence");
`endif

    // Reset right after three reads: nothing may come out from the reset edge onward.
    clear_q();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, BASE + 32'h24, 32'hFFFF_FFFF, 4'hF, 1'b1);
    p_r = p;
    idle(12);
    for (int k = 0; k < NK; k++) begin
      late = 0;
      foreach (rs[k][i]) if (rs[k][i] >= p_r) late++;
      chk("rst_flush", k, 32'(late), 32'd0);
      if (lat_of(k) >= 4) chk("rst_none", k, 32'(rq[k].size()), 32'd0);
    end
    step(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 1'b0);
    idle(9);
    for (int k = 0; k < NK; k++) chk("post_rst_read", k, rd[k], 32'hCAFE_F00D);
    step(1'b1, 1'b0, BASE + 32'h24, 32'h0, 4'h0, 1'b0);
    idle(9);
    for (int k = 0; k < NK; k++) chk("rst_write_drop", k, rd[k], 32'h0000_0009);
    $display("txn reset flush at cycle %0d", p_r);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      bit r, w, rst;
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, 15));
        3:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
        4:       a = ($urandom_range(0, 1) == 0) ? IRQA : IRQA + 32'd4;
        default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      a = a | 32'($urandom_range(0, 3));
      r   = ($urandom_range(0, 1) == 1);
      w   = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(r, w, a, $urandom, 4'($urandom_range(0, 15)), rst);
    end
    idle(10);
    $display("txn random traffic done at cycle %0d", p);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
